// File: rtl/infer_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : infer_batch_ctrl
// Purpose  : Batch sequencer for the CNN accelerator. For each image it loads
//            the image words into the image BRAM and captures the label. It
//            then starts the accelerator, waits for done and presents the
//            result on a valid/ready port, keeping a running mismatch count.
// Revision : 1.0 - initial release
// ============================================================================
module infer_batch_ctrl #(
  parameter int              IMG_WORDS = 900,
  parameter int              IMG_AW    = 10,
  parameter int              PS_W      = 4,
  parameter int              CNT_W     = 16,
  parameter int              TO_W      = 24,
  parameter logic [TO_W-1:0] TIMEOUT   = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [CNT_W-1:0]  cfg_batch,
  output logic              busy,
  output logic              batch_done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [31:0]       img_data,
  input  logic              lbl_valid,
  output logic              lbl_ready,
  input  logic [PS_W-1:0]   lbl_data,
  output logic              im_wen,
  output logic [IMG_AW-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [PS_W-1:0]   acc_predict,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_index,
  output logic [PS_W-1:0]   res_predict,
  output logic [PS_W-1:0]   res_label,
  output logic              res_match
);

  localparam int                c_WC_W  = $clog2(IMG_WORDS + 1);
  localparam logic [c_WC_W-1:0] c_WORDS = c_WC_W'(IMG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t              r_state, w_next_state;
  logic [CNT_W-1:0]    r_batch, r_index, r_err;
  logic [c_WC_W-1:0]   r_word_cnt;
  logic                r_lbl_cap, r_done_q, r_batch_done, r_timeout_err;
  logic [PS_W-1:0]     r_label, r_predict, r_res_label;
  logic                r_match;
  logic [TO_W-1:0]     r_to;
  logic                r_wen;
  logic [IMG_AW-1:0]   r_waddr;
  logic [31:0]         r_wdata;

  logic w_img_ready, w_lbl_ready, w_acc_start, w_res_valid;
  logic w_go_ok, w_go_zero, w_done_edge, w_timeout, w_res_hs, w_last;

  // State register; reset aborts any batch in progress without a done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode and per-state handshake/strobe generation
  always_comb begin
    w_next_state = r_state;
    w_img_ready  = 1'b0;
    w_lbl_ready  = 1'b0;
    w_acc_start  = 1'b0;
    w_res_valid  = 1'b0;
    w_go_ok      = 1'b0;
    w_go_zero    = 1'b0;
    w_done_edge  = 1'b0;
    w_timeout    = 1'b0;
    w_res_hs     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          if (cfg_batch != '0) begin
            w_go_ok      = 1'b1;
            w_next_state = S_LOAD;
          end else begin
            w_go_zero    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_img_ready = (r_word_cnt < c_WORDS);
        w_lbl_ready = !r_lbl_cap;
        // Wait for the final BRAM write to land before starting the accelerator
        if ((r_word_cnt == c_WORDS) && r_lbl_cap && !r_wen)
          w_next_state = S_START;
      end
      S_START: begin
        w_acc_start  = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        // Only a fresh rising edge counts; a level left over from the last image is ignored
        if (acc_done && !r_done_q) begin
          w_done_edge  = 1'b1;
          w_next_state = S_REPORT;
        end else if (r_to == TIMEOUT - 1'b1) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_REPORT: begin
        w_res_valid = 1'b1;
        if (res_ready) begin
          w_res_hs = 1'b1;
          if (r_index + 1'b1 == r_batch) begin
            w_last       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_LOAD;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Image/label stream capture and the registered BRAM write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt <= '0;
      r_lbl_cap  <= 1'b0;
      r_label    <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_wen <= 1'b0;
      if (w_img_ready && img_valid) begin
        r_wen      <= 1'b1;
        r_waddr    <= IMG_AW'(r_word_cnt);
        r_wdata    <= img_data;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (w_lbl_ready && lbl_valid) begin
        r_label   <= lbl_data;
        r_lbl_cap <= 1'b1;
      end
      // New batch or next image restarts the load bookkeeping
      if (w_go_ok || (w_res_hs && !w_last)) begin
        r_word_cnt <= '0;
        r_lbl_cap  <= 1'b0;
      end
    end
  end

  // Batch bookkeeping: index, error count, watchdog, status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_batch       <= '0;
      r_index       <= '0;
      r_err         <= '0;
      r_to          <= '0;
      r_done_q      <= 1'b0;
      r_batch_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done_q     <= acc_done;
      r_batch_done <= 1'b0;
      if (w_go_ok || w_go_zero) r_timeout_err <= 1'b0;
      if (w_go_zero)            r_batch_done  <= 1'b1;
      if (w_go_ok) begin
        r_batch <= cfg_batch;
        r_index <= '0;
        r_err   <= '0;
      end
      if (w_acc_start)           r_to <= '0;
      else if (r_state == S_RUN) r_to <= r_to + 1'b1;
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        r_batch_done  <= 1'b1;
      end
      if (w_res_hs) begin
        if (!r_match && (r_err != {CNT_W{1'b1}})) r_err <= r_err + 1'b1;
        if (w_last) r_batch_done <= 1'b1;
        else        r_index      <= r_index + 1'b1;
      end
    end
  end

  // Result capture on the done edge; held stable through REPORT and IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_predict   <= '0;
      r_res_label <= '0;
      r_match     <= 1'b0;
    end else if (w_done_edge) begin
      r_predict   <= acc_predict;
      r_res_label <= r_label;
      r_match     <= (acc_predict == r_label);
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign batch_done  = r_batch_done;
  assign timeout_err = r_timeout_err;
  assign err_cnt     = r_err;
  assign img_ready   = w_img_ready;
  assign lbl_ready   = w_lbl_ready;
  assign im_wen      = r_wen;
  assign im_waddr    = r_waddr;
  assign im_wdata    = r_wdata;
  assign acc_start   = w_acc_start;
  assign res_valid   = w_res_valid;
  assign res_index   = r_index;
  assign res_predict = r_predict;
  assign res_label   = r_res_label;
  assign res_match   = r_match;

endmodule
`default_nettype wire

// File: tb/tb_infer_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_infer_batch_ctrl
// Purpose  : Self-checking bench for infer_batch_ctrl with a behavioural
//            host, accelerator and result-sink model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_infer_batch_ctrl;
  localparam int              IMG_WORDS = 900;
  localparam int              IMG_AW    = 10;
  localparam int              PS_W      = 4;
  localparam int              CNT_W     = 16;
  localparam int              TO_W      = 24;
  localparam logic [TO_W-1:0] TIMEOUT   = 24'd100;

  logic              clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic [CNT_W-1:0]  cfg_batch = '0;
  logic              busy, batch_done, timeout_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              img_valid = 1'b0, img_ready;
  logic [31:0]       img_data = '0;
  logic              lbl_valid = 1'b0, lbl_ready;
  logic [PS_W-1:0]   lbl_data = '0;
  logic              im_wen;
  logic [IMG_AW-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              acc_start, acc_done = 1'b0;
  logic [PS_W-1:0]   acc_predict = '0;
  logic              res_valid, res_ready = 1'b0, res_match;
  logic [CNT_W-1:0]  res_index;
  logic [PS_W-1:0]   res_predict, res_label;

  always #5 clk = ~clk;

  infer_batch_ctrl #(
    .IMG_WORDS(IMG_WORDS), .IMG_AW(IMG_AW), .PS_W(PS_W), .CNT_W(CNT_W),
    .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst(rst), .go(go), .cfg_batch(cfg_batch), .busy(busy),
    .batch_done(batch_done), .timeout_err(timeout_err), .err_cnt(err_cnt),
    .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
    .lbl_valid(lbl_valid), .lbl_ready(lbl_ready), .lbl_data(lbl_data),
    .im_wen(im_wen), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .acc_start(acc_start), .acc_done(acc_done), .acc_predict(acc_predict),
    .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
    .res_predict(res_predict), .res_label(res_label), .res_match(res_match)
  );

  int n_tests = 0, n_fail = 0;
  int cur_img = -1, exp_wr = 0, start_cnt = 0, bd_cnt = 0;
  int lbl_arr[8], prd_arr[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int k, input int n);
    return 32'(k * 1000 + n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // BRAM write scoreboard: every image must be written exactly once, in order
  always @(negedge clk) begin
    if (im_wen) begin
      chk("wr_addr", 32'(im_waddr), exp_wr);
      chk("wr_data", im_wdata, word_of(cur_img, exp_wr));
      exp_wr++;
    end
    if (acc_start) begin
      chk("start_after_last_wr", exp_wr, IMG_WORDS);
      start_cnt++;
    end
    if (batch_done) bd_cnt++;
  end

  task automatic chk_idle_zero();
    chk("z_busy", busy, 0);           chk("z_img_ready", img_ready, 0);
    chk("z_lbl_ready", lbl_ready, 0); chk("z_im_wen", im_wen, 0);
    chk("z_im_waddr", im_waddr, 0);   chk("z_im_wdata", im_wdata, 0);
    chk("z_acc_start", acc_start, 0); chk("z_res_valid", res_valid, 0);
    chk("z_res_index", res_index, 0); chk("z_res_predict", res_predict, 0);
    chk("z_res_label", res_label, 0); chk("z_res_match", res_match, 0);
    chk("z_err_cnt", err_cnt, 0);     chk("z_timeout_err", timeout_err, 0);
    chk("z_batch_done", batch_done, 0);
  endtask

  task automatic start_batch(input int n);
    go = 1'b1;
    cfg_batch = CNT_W'(n);
    tick();
    go = 1'b0;
  endtask

  // Host model: image words (optional random gaps) and one label, concurrently
  task automatic feed(input bit gaps, input int lbl, input int lbl_dly, input int img_dly);
    int n, g1, g2;
    bit a1, a2;
    n = 0; g1 = 0; g2 = 0; a2 = 1'b0;
    fork
      begin
        repeat (img_dly) tick();
        while (n < IMG_WORDS && g1 < 20000) begin
          img_valid = !gaps || ($urandom_range(0, 3) != 0);
          img_data  = word_of(cur_img, n);
          @(negedge clk);
          a1 = img_valid && img_ready;
          tick();
          g1++;
          if (a1) n++;
        end
        img_valid = 1'b0;
      end
      begin
        repeat (lbl_dly) tick();
        lbl_valid = 1'b1;
        lbl_data  = PS_W'(lbl);
        while (!a2 && g2 < 20000) begin
          @(negedge clk);
          a2 = lbl_ready;
          tick();
          g2++;
        end
        lbl_valid = 1'b0;
      end
    join
    chk("img_words_fed", n, IMG_WORDS);
    chk("lbl_taken", a2, 1);
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = acc_start;
      if (!seen) tick();
    end
    chk("acc_start_seen", seen, 1);
    tick();
  endtask

  // One image end to end: load, accelerator reply after 50 cycles, result sink
  task automatic run_image(input int k, input int lbl, input int prd, input bit gaps,
                           input int lbl_dly, input int img_dly, input int stall,
                           input bit keep, input bit last, input int exp_err);
    bit early, stable;
    logic [31:0] s_idx, s_prd, s_lbl;
    cur_img++;
    exp_wr = 0;
    feed(gaps, lbl, lbl_dly, img_dly);
    wait_start();
    early = 1'b0;
    for (int i = 1; i < 50; i++) begin
      if (i == 10) acc_done = 1'b0;
      @(negedge clk);
      if (res_valid) early = 1'b1;
      tick();
    end
    chk("no_early_result", early, 0);
    acc_done = 1'b1;
    acc_predict = PS_W'(prd);
    @(negedge clk);
    chk("res_not_yet", res_valid, 0);
    tick();
    @(negedge clk);
    chk("res_valid", res_valid, 1);
    chk("res_index", res_index, k);
    chk("res_predict", res_predict, prd);
    chk("res_label", res_label, lbl);
    chk("res_match", res_match, prd == lbl);
    s_idx = 32'(res_index); s_prd = 32'(res_predict); s_lbl = 32'(res_label);
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      @(negedge clk);
      if (!res_valid || 32'(res_index) != s_idx || 32'(res_predict) != s_prd ||
          32'(res_label) != s_lbl) stable = 1'b0;
    end
    if (stall > 0) chk("res_stable_stall", stable, 1);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    if (!keep) acc_done = 1'b0;
    @(negedge clk);
    chk("res_drop", res_valid, 0);
    chk("err_cnt", err_cnt, exp_err);
    chk("batch_done", batch_done, last);
    chk("busy_after_res", busy, !last);
    tick();
  endtask

  task automatic run_batch(input int nb, input bit gaps, input int stall,
                           input bit keep, input bit lbl_first);
    int err, bd0, st0, ld, id;
    err = 0; bd0 = bd_cnt; st0 = start_cnt;
    start_batch(nb);
    @(negedge clk);
    chk("go_busy", busy, 1);
    chk("go_terr_clr", timeout_err, 0);
    chk("go_err_clr", err_cnt, 0);
    tick();
    for (int k = 0; k < nb; k++) begin
      if (prd_arr[k] != lbl_arr[k] && err < 65535) err++;
      ld = lbl_first ? 0 : int'($urandom_range(0, 1100));
      id = lbl_first ? 20 : 0;
      run_image(k, lbl_arr[k], prd_arr[k], gaps, ld, id, stall,
                keep && (k < nb - 1), k == nb - 1, err);
    end
    chk("batch_done_once", bd_cnt - bd0, 1);
    chk("acc_start_count", start_cnt - st0, nb);
  endtask

  task automatic fill_rand(input int nb);
    for (int k = 0; k < nb; k++) begin
      lbl_arr[k] = int'($urandom_range(0, 15));
      prd_arr[k] = ($urandom_range(0, 1) == 1) ? lbl_arr[k] : int'($urandom_range(0, 15));
    end
  endtask

  initial begin
    int cnt, bd0;
    bit got;
    #2 rst = 1'b0;
    repeat (3) tick();
    chk_idle_zero();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single image, label 7, predict 7
    lbl_arr[0] = 7; prd_arr[0] = 7;
    run_batch(1, 1'b0, 0, 1'b0, 1'b0);

    // Three images, label before image, one mismatch
    lbl_arr[0] = 1; lbl_arr[1] = 2; lbl_arr[2] = 3;
    prd_arr[0] = 1; prd_arr[1] = 5; prd_arr[2] = 3;
    run_batch(3, 1'b0, 0, 1'b0, 1'b1);

    // Backpressure on both the image stream and the result port
    fill_rand(2);
    run_batch(2, 1'b1, 20, 1'b0, 1'b0);

    // Done level held over from the previous image
    fill_rand(2);
    run_batch(2, 1'b0, 3, 1'b1, 1'b0);

    // Watchdog: accelerator never answers
    start_batch(1);
    cur_img++;
    exp_wr = 0;
    feed(1'b0, 3, 0, 0);
    wait_start();
    @(negedge clk);
    cnt = 1;
    got = batch_done;
    for (int i = 0; i < 500 && !got; i++) begin
      tick();
      @(negedge clk);
      cnt++;
      got = batch_done;
    end
    chk("wd_batch_done_cycle", cnt, 32'(TIMEOUT) + 1);
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_busy", busy, 0);
    tick();
    lbl_arr[0] = 4; prd_arr[0] = 9;
    run_batch(1, 1'b0, 0, 1'b0, 1'b0);

    // Zero-length batch
    bd0 = bd_cnt;
    start_batch(0);
    @(negedge clk);
    chk("zb_batch_done", batch_done, 1);
    chk("zb_busy", busy, 0);
    tick();
    @(negedge clk);
    chk("zb_done_pulse_end", batch_done, 0);
    chk("zb_busy2", busy, 0);
    chk("zb_done_count", bd_cnt - bd0, 1);
    tick();

    // Asynchronous reset in the middle of an image load
    start_batch(2);
    cur_img++;
    exp_wr = 0;
    for (int i = 0; i < 30; i++) begin
      img_valid = 1'b1;
      img_data  = word_of(cur_img, i);
      tick();
    end
    img_valid = 1'b0;
    bd0 = bd_cnt;
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_idle_zero();
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_no_done", bd_cnt - bd0, 0);
    chk("rst_idle", busy, 0);
    tick();

    // Recovery after reset
    fill_rand(1);
    run_batch(1, 1'b1, 5, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/infer_batch_ctrl.md
Name: infer_batch_ctrl

Overview:
- Batch sequencer for the CNN accelerator `Top`.
- Per image: streams 900 32-bit image words into the image BRAM and captures the label. Then pulses `start` to `Top`, waits for `done` and presents the result on a valid/ready result port.
- Repeats for a configured batch and keeps a running mismatch (error) count.
- Sits between the host/DMA stream and `Top` plus its image BRAM; replaces hand-driven start/done sequencing.

Parameters:
- IMG_WORDS, 900, image words per inference
- IMG_AW, 10, image BRAM address width
- PS_W, 4, predict/label width
- CNT_W, 16, batch, index and error counter width
- TO_W, 24, run watchdog counter width
- TIMEOUT, 24'hFFFFFF, max cycles in RUN before abort

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- go  in  1  one-cycle batch start request
- cfg_batch  in  CNT_W  number of images, sampled on accepted go
- busy  out  1  high whenever state != IDLE
- batch_done  out  1  one-cycle pulse at batch end or abort
- timeout_err  out  1  sticky; set on watchdog abort, cleared by next accepted go
- err_cnt  out  CNT_W  mismatches in current/last batch
- img_valid  in  1  image word stream valid
- img_ready  out  1  image word stream ready
- img_data  in  32  image word
- lbl_valid  in  1  label valid
- lbl_ready  out  1  label ready
- lbl_data  in  PS_W  label
- im_wen  out  1  image BRAM write enable
- im_waddr  out  IMG_AW  image BRAM write address
- im_wdata  out  32  image BRAM write data
- acc_start  out  1  start pulse to `Top`
- acc_done  in  1  done level from `Top`
- acc_predict  in  PS_W  predict from `Top`
- res_valid  out  1  result valid
- res_ready  in  1  result ready
- res_index  out  CNT_W  image index within batch, 0-based
- res_predict  out  PS_W  captured predict
- res_label  out  PS_W  captured label
- res_match  out  1  res_predict == res_label

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, timeout_err 0. Reset mid-batch aborts immediately; there is no batch_done pulse on reset.
- States: IDLE, LOAD, START, RUN, REPORT.
- Stream handshake: transfer occurs when valid && ready on the same edge.
- IDLE:
  - go with cfg_batch != 0: latch batch; clear err_cnt, index, word_cnt, label-captured flag and timeout_err; go to LOAD.
  - go with cfg_batch == 0: pulse batch_done next cycle, stay IDLE.
  - go outside IDLE: ignored.
- LOAD:
  - img_ready = (word_cnt < IMG_WORDS).
  - Each image transfer registers im_wen=1, im_waddr=word_cnt, im_wdata=img_data on the next cycle, then word_cnt increments. Addresses run 0..IMG_WORDS-1 with no wrap. im_wen is 0 in all other cycles.
  - lbl_ready = !label_captured. The label may arrive before, during or after the image words.
  - Exit to START when word_cnt == IMG_WORDS, the label is captured and no BRAM write is pending. The last write therefore lands at least one cycle before acc_start.
- START: acc_start=1 for exactly one cycle; clear watchdog; go to RUN.
- RUN:
  - Completion is the rising edge of acc_done (acc_done && !done_q, done_q registered). A done level held over from the previous image is ignored.
  - On the edge: capture acc_predict; go to REPORT.
  - Watchdog increments each RUN cycle. At TIMEOUT: set timeout_err, pulse batch_done, go to IDLE. err_cnt keeps its partial value.
- REPORT:
  - res_valid=1 with fields held stable until res_ready.
  - On handshake: if !res_match, err_cnt++ (saturating at all-ones).
  - If index+1 == batch: pulse batch_done, go to IDLE. Otherwise index++, clear word_cnt and the label flag, go to LOAD.
- res_valid rises the cycle after the done edge and drops the cycle after the handshake.
- err_cnt and res_* hold their values in IDLE.

Test Plan:
- Batch of 1: cfg_batch=1; 900 words 0..899; label=7; acc_done rises 50 cycles after acc_start with predict=7. Expect 900 writes at addr 0..899, one acc_start, res_index=0, res_match=1, err_cnt=0, batch_done once.
- Batch of 3 with labels 1,2,3, predicts 1,5,3, label sent before image: expect res_index 0,1,2, res_match 1,0,1, final err_cnt=1.
- Backpressure: random gaps on img_valid, res_ready held low 20 cycles. Expect no lost or duplicate writes, res fields stable while stalled, no acc_start before the last write.
- acc_done held high from the previous image: expect no false completion until a fresh rising edge.
- Watchdog with TIMEOUT=100, acc_done never rises: expect batch_done at cycle 100 of RUN, timeout_err=1, busy=0. A following go clears timeout_err.
- cfg_batch=0: expect batch_done pulse, busy stays 0. Reset asserted mid-LOAD: all outputs 0 asynchronously, state IDLE.
